// File: rtl/prog_tt_pkg.sv
// Shared types and constants for the programmable truth-table engine.
package prog_tt_pkg;

    localparam int unsigned TT_IN_W_DEF  = 4;
    localparam int unsigned TT_OUT_W_DEF = 2;

    typedef enum logic {
        TT_IDLE  = 1'b0,
        TT_SWEEP = 1'b1
    } tt_state_e;

    // Number of table entries for a given input code width.
    function automatic int unsigned tt_depth(input int unsigned in_w);
        return 32'd1 << in_w;
    endfunction

endpackage

// File: rtl/prog_truth_table_if.sv
// Lookup / write / sweep bus of prog_truth_table.
// PROG_TRUTH_TABLE_PARITY_EN adds inj_par_err and par_err.
interface prog_truth_table_if
    import prog_tt_pkg::*;
#(
    parameter int unsigned IN_W  = TT_IN_W_DEF,
    parameter int unsigned OUT_W = TT_OUT_W_DEF
);
    logic             wr_en;
    logic [IN_W-1:0]  wr_addr;
    logic [OUT_W-1:0] wr_data;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             sweep_start;
    logic             out_valid;
    logic             out_ready;
    logic [IN_W-1:0]  out_code;
    logic [OUT_W-1:0] out_f;
    logic             sweep_busy;
    logic             sweep_done;
`ifdef PROG_TRUTH_TABLE_PARITY_EN
    logic             inj_par_err;
    logic             par_err;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, in_valid, in_code, sweep_start, out_ready,
        input  in_ready, out_valid, out_code, out_f, sweep_busy, sweep_done
`ifdef PROG_TRUTH_TABLE_PARITY_EN
        , output inj_par_err
        , input  par_err
`endif
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, in_valid, in_code, sweep_start, out_ready,
        output in_ready, out_valid, out_code, out_f, sweep_busy, sweep_done
`ifdef PROG_TRUTH_TABLE_PARITY_EN
        , input  inj_par_err
        , output par_err
`endif
    );

endinterface

// File: rtl/prog_truth_table_mem.sv
// tt_mem: 2^AW x DW register array, one write port, one combinational read port.
module tt_mem
    import prog_tt_pkg::*;
#(
    parameter int unsigned AW = TT_IN_W_DEF,
    parameter int unsigned DW = TT_OUT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int unsigned DEPTH = tt_depth(AW);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read sees the pre-write contents when addresses collide.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/prog_truth_table.sv
// Programmable registered truth table with lookup handshake and full-table SWEEP.
// Optional PROG_TRUTH_TABLE_PARITY_EN stores an even-parity bit per entry.
module prog_truth_table
    import prog_tt_pkg::*;
#(
    parameter int unsigned IN_W  = TT_IN_W_DEF,
    parameter int unsigned OUT_W = TT_OUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prog_truth_table_if.slave    bus
);
    localparam int unsigned DEPTH = tt_depth(IN_W);
    localparam int unsigned CNT_W = IN_W + 1;
`ifdef PROG_TRUTH_TABLE_PARITY_EN
    localparam int unsigned MEM_W = OUT_W + 1;
`else
    localparam int unsigned MEM_W = OUT_W;
`endif

    tt_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_c, can_load_c, done_d;
    logic [IN_W-1:0]  rd_addr_c;
    logic [MEM_W-1:0] wr_word_c, rd_word_c;

    logic             out_valid_q, sweep_busy_q, sweep_done_q;
    logic [IN_W-1:0]  out_code_q;
    logic [OUT_W-1:0] out_f_q;

`ifdef PROG_TRUTH_TABLE_PARITY_EN
    logic par_err_q;
    assign wr_word_c = {(^bus.wr_data) ^ bus.inj_par_err, bus.wr_data};
`else
    assign wr_word_c = bus.wr_data;
`endif

    assign can_load_c = !out_valid_q || bus.out_ready;
    assign rd_addr_c  = (state_q == TT_SWEEP) ? cnt_q[IN_W-1:0] : bus.in_code;

    tt_mem #(.AW(IN_W), .DW(MEM_W)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (wr_word_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_word_c)
    );

    // Next state: lookups in IDLE, counter-driven emission in SWEEP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            TT_IDLE: begin
                load_c = bus.in_valid && can_load_c;
                if (bus.sweep_start) begin
                    state_d = TT_SWEEP;
                    cnt_d   = '0;
                end
            end
            TT_SWEEP: begin
                if (cnt_q != CNT_W'(DEPTH)) begin
                    load_c = can_load_c;
                    if (can_load_c) cnt_d = cnt_q + CNT_W'(1);
                end else if (out_valid_q && bus.out_ready) begin
                    state_d = TT_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = TT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TT_IDLE;
            cnt_q        <= '0;
            sweep_busy_q <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sweep_busy_q <= (state_d == TT_SWEEP);
            sweep_done_q <= done_d;
        end
    end

    // Single output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_f_q     <= '0;
`ifdef PROG_TRUTH_TABLE_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else if (load_c) begin
            out_valid_q <= 1'b1;
            out_code_q  <= rd_addr_c;
            out_f_q     <= rd_word_c[OUT_W-1:0];
`ifdef PROG_TRUTH_TABLE_PARITY_EN
            par_err_q   <= ^rd_word_c;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = (state_q == TT_IDLE) && can_load_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_code   = out_code_q;
    assign bus.out_f      = out_f_q;
    assign bus.sweep_busy = sweep_busy_q;
    assign bus.sweep_done = sweep_done_q;
`ifdef PROG_TRUTH_TABLE_PARITY_EN
    assign bus.par_err    = par_err_q;
`endif

endmodule

// File: tb/tb_prog_truth_table.sv
// Self-checking bench for prog_truth_table against a transaction-level table model.
// Parity checks are included when PROG_TRUTH_TABLE_PARITY_EN is defined.
module tb_prog_truth_table;
    import prog_tt_pkg::*;

    localparam int unsigned IN_W  = 4;
    localparam int unsigned OUT_W = 2;
    localparam int          DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_truth_table_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    prog_truth_table #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model: table contents plus the one visible result slot.
    logic [OUT_W-1:0] tab [DEPTH];
    bit               tab_bad [DEPTH];
    bit               m_valid, m_sweep, m_done, m_perr;
    logic [IN_W-1:0]  m_code;
    logic [OUT_W-1:0] m_f;
    int               m_next;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin tab[i] = '0; tab_bad[i] = 1'b0; end
        m_valid = 0; m_sweep = 0; m_done = 0; m_perr = 0;
        m_code = '0; m_f = '0; m_next = 0;
    endtask

    function automatic bit exp_ready();
        return !m_sweep && (!m_valid || bus.out_ready);
    endfunction

    task automatic model_load(input int code);
        m_valid = 1; m_code = IN_W'(code); m_f = tab[code]; m_perr = tab_bad[code];
    endtask

    // Effect of one rising edge given the inputs currently driven.
    task automatic model_edge();
        bit can;
        can = !m_valid || bus.out_ready;
        m_done = 0;
        if (!m_sweep) begin
            if (bus.in_valid && can) model_load(int'(bus.in_code));
            else if (bus.out_ready) m_valid = 0;
            if (bus.sweep_start) begin m_sweep = 1; m_next = 0; end
        end else if (m_next < DEPTH && can) begin
            model_load(m_next);
            m_next++;
        end else begin
            if (m_next == DEPTH && m_valid && bus.out_ready) begin m_sweep = 0; m_done = 1; end
            if (bus.out_ready) m_valid = 0;
        end
        if (bus.wr_en) begin
            tab[bus.wr_addr] = bus.wr_data;
`ifdef PROG_TRUTH_TABLE_PARITY_EN
            tab_bad[bus.wr_addr] = bus.inj_par_err;
`endif
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.in_valid = 0; bus.in_code = '0; bus.sweep_start = 0; bus.out_ready = 1;
`ifdef PROG_TRUTH_TABLE_PARITY_EN
        bus.inj_par_err = 0;
`endif
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done} !== 9'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done});
        end
        rst_n = 1;
        settle();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_lookup();
        drive_idle();
        bus.in_valid = 1; bus.in_code = 4'hA;
        settle();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL lookup_ready: got %b expected 1", bus.in_ready); end
        tick();
        checks++;
        if ({bus.out_valid, bus.out_code, bus.out_f} !== {1'b1, 4'hA, 2'b00}) begin
            errors++;
            $display("FAIL lookup_A: got %b/%h/%b expected 1/a/00", bus.out_valid, bus.out_code, bus.out_f);
        end
        drive_idle(); settle(); tick();
    endtask

    task automatic test_write_rdw();
        logic [OUT_W-1:0] exp_f [3];
        exp_f[0] = 2'b11; exp_f[1] = 2'b11; exp_f[2] = 2'b01;
        drive_idle();
        bus.wr_en = 1; bus.wr_addr = 4'd5; bus.wr_data = 2'b11;
        settle(); tick();
        for (int s = 0; s < 3; s++) begin
            bus.wr_en = (s == 1); bus.wr_data = 2'b01;
            bus.in_valid = 1; bus.in_code = 4'd5;
            settle(); tick();
            checks++;
            if ({bus.out_valid, bus.out_f} !== {1'b1, exp_f[s]}) begin
                errors++;
                $display("FAIL write_rdw step%0d: got v=%b f=%b expected v=1 f=%b", s, bus.out_valid, bus.out_f, exp_f[s]);
            end
        end
        drive_idle(); settle(); tick();
    endtask

    task automatic test_back_to_back();
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1; bus.in_code = IN_W'(i);
            settle();
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, bus.in_ready); end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_code} !== {1'b1, IN_W'(i)}) begin
                errors++;
                $display("FAIL b2b_result%0d: got v=%b code=%h expected v=1 code=%h", i, bus.out_valid, bus.out_code, i);
            end
        end
        bus.in_code = 4'd9; bus.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", k, bus.in_ready); end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_code, bus.out_f} !== {1'b1, 4'd3, tab[3]}) begin
                errors++;
                $display("FAIL stall_hold%0d: got %b/%h/%b expected 1/3/%b", k, bus.out_valid, bus.out_code, bus.out_f, tab[3]);
            end
        end
        bus.out_ready = 1;
        settle(); tick();
        checks++;
        if ({bus.out_valid, bus.out_code} !== {1'b1, 4'd9}) begin
            errors++;
            $display("FAIL stall_release: got v=%b code=%h expected v=1 code=9", bus.out_valid, bus.out_code);
        end
        drive_idle(); settle(); tick();
    endtask

    // Start a sweep and track every accepted result against the model table.
    task automatic run_sweep(input bit toggle);
        int exp_code, dones;
        exp_code = 0; dones = 0;
        drive_idle();
        bus.sweep_start = 1;
        settle(); tick();
        bus.sweep_start = 0;
        for (int c = 0; c < 80; c++) begin
            bus.out_ready = toggle ? (c % 2 == 0) : 1'b1;
            bus.sweep_start = (c == 5);
            settle();
            checks++;
            if (bus.in_ready !== exp_ready()) begin
                errors++; $display("FAIL sweep_in_ready c%0d: got %b expected %b", c, bus.in_ready, exp_ready());
            end
            if (bus.out_valid && bus.out_ready && exp_code < DEPTH) begin
                checks++;
                if ({bus.out_code, bus.out_f} !== {IN_W'(exp_code), tab[exp_code]}) begin
                    errors++;
                    $display("FAIL sweep_result: got code=%h f=%b expected code=%h f=%b", bus.out_code, bus.out_f, exp_code, tab[exp_code]);
                end
                exp_code++;
            end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done} !==
                {m_valid, m_code, m_f, m_sweep, m_done}) begin
                errors++;
                $display("FAIL sweep_state c%0d: got %h expected %h", c,
                         {bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done},
                         {m_valid, m_code, m_f, m_sweep, m_done});
            end
            if (bus.sweep_done) dones++;
        end
        checks++;
        if (exp_code != DEPTH || dones != 1) begin
            errors++; $display("FAIL sweep_count: got results=%0d dones=%0d expected results=16 dones=1", exp_code, dones);
        end
    endtask

    task automatic test_sweep();
        drive_idle();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en = 1; bus.wr_addr = IN_W'(i); bus.wr_data = OUT_W'(i);
            settle(); tick();
        end
        run_sweep(1'b1);
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        found = 0;
        drive_idle();
        bus.sweep_start = 1;
        settle(); tick();
        bus.sweep_start = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            settle(); tick();
            if (bus.out_valid && bus.out_code == 4'd7) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_sweep_reach7: got found=0 expected 1"); end
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done} !== 9'h000) begin
            errors++;
            $display("FAIL mid_sweep_reset: got %h expected 000",
                     {bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done});
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            settle(); tick();
            checks++;
            if ({bus.out_valid, bus.sweep_busy, bus.sweep_done} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_quiet c%0d: got v/busy/done=%b expected 000", c,
                         {bus.out_valid, bus.sweep_busy, bus.sweep_done});
            end
        end
        run_sweep(1'b0);
    endtask

`ifdef PROG_TRUTH_TABLE_PARITY_EN
    task automatic test_parity();
        drive_idle();
        bus.wr_en = 1; bus.wr_addr = 4'd3; bus.wr_data = 2'b01; bus.inj_par_err = 1;
        settle(); tick();
        bus.wr_en = 0; bus.inj_par_err = 0;
        bus.in_valid = 1; bus.in_code = 4'd3;
        settle(); tick();
        checks++;
        if ({bus.out_f, bus.par_err} !== {2'b01, 1'b1}) begin
            errors++; $display("FAIL parity_bad: got f=%b par_err=%b expected f=01 par_err=1", bus.out_f, bus.par_err);
        end
        bus.in_code = 4'd2;
        settle(); tick();
        checks++;
        if (bus.par_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", bus.par_err); end
        drive_idle(); settle(); tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.wr_en       = ($urandom_range(3) == 0);
            bus.wr_addr     = IN_W'($urandom);
            bus.wr_data     = OUT_W'($urandom);
            bus.in_valid    = ($urandom_range(9) < 6);
            bus.in_code     = IN_W'($urandom);
            bus.out_ready   = ($urandom_range(9) < 7);
            bus.sweep_start = ($urandom_range(39) == 0);
`ifdef PROG_TRUTH_TABLE_PARITY_EN
            bus.inj_par_err = ($urandom_range(9) == 0);
`endif
            settle();
            checks++;
            if (bus.in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_in_ready c%0d: got %b expected %b", c, bus.in_ready, exp_ready());
            end
            tick();
            checks++;
            if ({bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done} !==
                {m_valid, m_code, m_f, m_sweep, m_done}) begin
                errors++;
                $display("FAIL rand_state c%0d: got %h expected %h", c,
                         {bus.out_valid, bus.out_code, bus.out_f, bus.sweep_busy, bus.sweep_done},
                         {m_valid, m_code, m_f, m_sweep, m_done});
            end
`ifdef PROG_TRUTH_TABLE_PARITY_EN
            if (m_valid) begin
                checks++;
                if (bus.par_err !== m_perr) begin
                    errors++; $display("FAIL rand_par_err c%0d: got %b expected %b", c, bus.par_err, m_perr);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_write_rdw();
        test_back_to_back();
        test_sweep();
        test_reset_mid_sweep();
`ifdef PROG_TRUTH_TABLE_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
